sumador_serial: RTL

- Bit-serial ripple adder: adds two N-bit operands plus a carry-in, one bit per clock, LSB first, using a single 1-bit full-adder cell and a carry register.
- It is the additive counterpart of the lab's 1-bit subtractor cell.
- It sits beside the subtractor datapath as a sequential, area-minimal adder with a start/done handshake.

---
 rtl/sumador_serial.sv | 119 +++++++++++
 1 files changed

// File: rtl/sumador_serial.sv
`default_nettype none
// ============================================================================
// Module      : sumador_serial
// Description : Bit-serial ripple adder. Adds two N-bit operands plus a
//               carry-in one bit per clock, LSB first, with a single
//               full-adder cell, a carry register and a start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module sumador_serial #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] S,
  output logic         Cout
);

  // Counter must hold 0..N-1; keep at least one bit so N=1 still has a counter.
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;

  logic [N-1:0]   r_sha;
  logic [N-1:0]   r_shb;
  logic [N-1:0]   r_res;
  logic           r_carry;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_s;
  logic           r_cout;

  logic           w_sbit;
  logic           w_carry_nxt;
  logic           w_last;
  logic           w_accept;
  logic [N-1:0]   w_res_nxt;

  // Single full-adder cell working on the current LSBs.
  assign w_sbit      = r_sha[0] ^ r_shb[0] ^ r_carry;
  assign w_carry_nxt = (r_sha[0] & r_shb[0]) | (r_carry & (r_sha[0] ^ r_shb[0]));
  assign w_last      = (r_cnt == CW'(N - 1));

  // New sum bit enters at the MSB; after N shifts the first bit lands at bit 0.
  // Shifting the concatenation keeps this valid for N=1 as well.
  assign w_res_nxt   = N'({w_sbit, r_res} >> 1);

  // A new operation is only taken when no addition is in flight.
  assign w_accept    = start && ((r_state == IDLE) || (r_state == DONE));

  // Handshake outputs decode the state only, never the inputs.
  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign S    = r_s;
  assign Cout = r_cout;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; DONE may chain straight into RUN for back-to-back work.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: operand capture, serial add, and result publication at the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sha   <= '0;
      r_shb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_sha   <= A;
      r_shb   <= B;
      r_carry <= Cin;
      r_res   <= '0;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_sha   <= r_sha >> 1;
      r_shb   <= r_shb >> 1;
      r_carry <= w_carry_nxt;
      r_res   <= w_res_nxt;
      r_cnt   <= r_cnt + CW'(1);
      // Outputs only ever show a complete sum, never partial bits.
      if (w_last) begin
        r_s    <= w_res_nxt;
        r_cout <= w_carry_nxt;
      end
    end
  end

endmodule
`default_nettype wire
